m_ld_unit: RTL and testbench

//  M-stage load reader: read-side counterpart of the store byte-enable path. Takes a load
//  (sel code + byte address), checks alignment, issues a word read on the data bus with a
//  req/ready handshake, extracts and sign/zero-extends byte/half/word, holds result for W.

---
 rtl/m_ld_unit_pkg.sv | 50 +++++
 rtl/m_ld_unit_ld_extend.sv | 46 ++++
 rtl/m_ld_unit.sv | 173 +++++++++++++++++
 tb/tb_m_ld_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_ld_unit_pkg.sv
// -----------------------------------------------------------------------------
// m_ld_unit_pkg
// Shared definitions for the M-stage memory access path: the load/store
// selector codes used by the decoder, the load reader state encoding and
// small helpers that classify a load request.
// No ports (package).
// -----------------------------------------------------------------------------
package m_ld_unit_pkg;

    // Load selector codes; 0, 6 and 7 mean "no load this cycle".
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LW   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LHU  = 3'd3;
    localparam logic [2:0] LD_LB   = 3'd4;
    localparam logic [2:0] LD_LBU  = 3'd5;

    // Store selector codes, shared with the store byte-enable path.
    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_SW   = 3'd1;
    localparam logic [2:0] ST_SH   = 3'd2;
    localparam logic [2:0] ST_SB   = 3'd3;

    // Load reader states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } ld_state_e;

    // A selector names a real load only in the range LW..LBU.
    function automatic logic ld_is_legal(input logic [2:0] sel);
        return (sel >= LD_LW) && (sel <= LD_LBU);
    endfunction

    // Words need a 4-byte boundary, halves a 2-byte one; bytes never trap.
    function automatic logic ld_is_misaligned(input logic [2:0] sel,
                                              input logic [1:0] addr10);
        logic mis;
        mis = 1'b0;
        case (sel)
            LD_LW:         mis = (addr10 != 2'b00);
            LD_LH, LD_LHU: mis = addr10[0];
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/m_ld_unit_ld_extend.sv
// -----------------------------------------------------------------------------
// ld_extend
// Combinational load data extractor: picks the word, half or byte addressed
// by the low address bits out of the 32-bit bus word and sign- or
// zero-extends it to 32 bits according to the load selector.
// Ports:
//   sel_i     load selector (LD_LW..LD_LBU, anything else gives 0)
//   addr10_i  byte offset within the word
//   rdata_i   raw bus read data
//   data_o    extended load result
// -----------------------------------------------------------------------------
module ld_extend
    import m_ld_unit_pkg::*;
(
    input  logic [2:0]  sel_i,
    input  logic [1:0]  addr10_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [15:0] half_val;
    logic [7:0]  byte_val;

    // Lane selection first, then extension by selector.
    always_comb begin
        half_val = addr10_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        byte_val = rdata_i[7:0];
        case (addr10_i)
            2'd0:    byte_val = rdata_i[7:0];
            2'd1:    byte_val = rdata_i[15:8];
            2'd2:    byte_val = rdata_i[23:16];
            default: byte_val = rdata_i[31:24];
        endcase

        data_o = '0;
        case (sel_i)
            LD_LW:   data_o = rdata_i;
            LD_LH:   data_o = {{16{half_val[15]}}, half_val};
            LD_LHU:  data_o = {16'h0000, half_val};
            LD_LB:   data_o = {{24{byte_val[7]}}, byte_val};
            LD_LBU:  data_o = {24'h000000, byte_val};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/m_ld_unit.sv
// -----------------------------------------------------------------------------
// m_ld_unit
// M-stage load reader. Accepts a load from the pipeline, traps misaligned
// accesses, performs one word read on the data bus with a req/ready
// handshake, extracts/extends the result and holds it until W takes it.
// The M stage is stalled while the bus read is outstanding.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   ld_start_i          load presented this cycle
//   ld_sel_i, ld_addr_i load type and byte address
//   flush_i             discard the in-flight load
//   w_accept_i          W stage consumes ld_data_o
//   dm_req_o, dm_addr_o bus read request and word-aligned address
//   dm_ready_i, dm_rdata_i  bus read completion and data
//   ld_busy_o           stall request to M (combinational)
//   ld_valid_o, ld_data_o   extended result and its valid flag
//   ld_adel_o           misaligned-load pulse
//   ld_timeout_o        bus timeout pulse
// -----------------------------------------------------------------------------
module m_ld_unit
    import m_ld_unit_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ld_start_i,
    input  logic [2:0]  ld_sel_i,
    input  logic [31:0] ld_addr_i,
    input  logic        flush_i,
    input  logic        w_accept_i,
    output logic        dm_req_o,
    output logic [31:0] dm_addr_o,
    input  logic        dm_ready_i,
    input  logic [31:0] dm_rdata_i,
    output logic        ld_busy_o,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic        ld_adel_o,
    output logic        ld_timeout_o
);

    // The counter only has to reach BUS_TIMEOUT-1 before the timeout fires.
    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    ld_state_e        state_q;
    logic [2:0]       sel_q;
    logic [1:0]       addr10_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dm_req_q;
    logic [31:0]      dm_addr_q;
    logic             ld_valid_q;
    logic [31:0]      ld_data_q;
    logic             ld_adel_q;
    logic             ld_timeout_q;

    logic [31:0]      ext_data_d;
    logic             can_start_d;
    logic             start_legal_d;
    logic             start_mis_d;
    logic             start_go_d;
    logic             timeout_hit_d;

    ld_extend u_ld_extend (
        .sel_i    (sel_q),
        .addr10_i (addr10_q),
        .rdata_i  (dm_rdata_i),
        .data_o   (ext_data_d)
    );

    // A new load may be taken from IDLE, or from HOLD in the same cycle the
    // W stage drains the previous result. flush always beats a start.
    always_comb begin
        can_start_d   = (state_q == S_IDLE) || ((state_q == S_HOLD) && w_accept_i);
        start_legal_d = ld_start_i && ld_is_legal(ld_sel_i);
        start_mis_d   = ld_is_misaligned(ld_sel_i, ld_addr_i[1:0]);
        start_go_d    = !flush_i && can_start_d && start_legal_d && !start_mis_d;
        timeout_hit_d = (BUS_TIMEOUT != 32'd0) &&
                        (32'(cnt_q) == (BUS_TIMEOUT - 32'd1));
    end

    // Stall covers the issuing cycle and every cycle the bus read is open.
    assign ld_busy_o = (state_q == S_REQ) || (state_q == S_DRAIN) || start_go_d;

    // Main FSM with registered outputs. A bus response in the same cycle as
    // the timeout limit counts as success. DRAIN keeps the request up so a
    // flushed read still completes its handshake; the data is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            sel_q        <= LD_NONE;
            addr10_q     <= 2'b00;
            cnt_q        <= '0;
            dm_req_q     <= 1'b0;
            dm_addr_q    <= '0;
            ld_valid_q   <= 1'b0;
            ld_data_q    <= '0;
            ld_adel_q    <= 1'b0;
            ld_timeout_q <= 1'b0;
        end else begin
            ld_adel_q    <= 1'b0;
            ld_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (flush_i) begin
                        state_q    <= S_IDLE;
                        ld_valid_q <= 1'b0;
                    end else if (can_start_d) begin
                        state_q    <= S_IDLE;
                        ld_valid_q <= 1'b0;
                        if (start_legal_d) begin
                            if (start_mis_d) begin
                                ld_adel_q <= 1'b1;
                            end else begin
                                sel_q     <= ld_sel_i;
                                addr10_q  <= ld_addr_i[1:0];
                                dm_addr_q <= {ld_addr_i[31:2], 2'b00};
                                dm_req_q  <= 1'b1;
                                cnt_q     <= '0;
                                state_q   <= S_REQ;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (dm_ready_i) begin
                        dm_req_q <= 1'b0;
                        if (flush_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            ld_data_q  <= ext_data_d;
                            ld_valid_q <= 1'b1;
                            state_q    <= S_HOLD;
                        end
                    end else if (timeout_hit_d) begin
                        dm_req_q     <= 1'b0;
                        ld_timeout_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (flush_i) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (dm_ready_i) begin
                        dm_req_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (timeout_hit_d) begin
                        dm_req_q     <= 1'b0;
                        ld_timeout_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    dm_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign dm_req_o     = dm_req_q;
    assign dm_addr_o    = dm_addr_q;
    assign ld_valid_o   = ld_valid_q;
    assign ld_data_o    = ld_data_q;
    assign ld_adel_o    = ld_adel_q;
    assign ld_timeout_o = ld_timeout_q;

endmodule

// File: tb/tb_m_ld_unit.sv
// -----------------------------------------------------------------------------
// tb_m_ld_unit
// Directed bench for the M-stage load reader. Inputs change on the falling
// clock edge; outputs are observed 1 ns after it. The unit is built with a
// short bus timeout so the timeout path is reachable quickly.
// -----------------------------------------------------------------------------
module tb_m_ld_unit;

    localparam logic [2:0] SEL_LW  = 3'd1;
    localparam logic [2:0] SEL_LH  = 3'd2;
    localparam logic [2:0] SEL_LHU = 3'd3;
    localparam logic [2:0] SEL_LB  = 3'd4;
    localparam logic [2:0] SEL_LBU = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start;
    logic [2:0]  ld_sel;
    logic [31:0] ld_addr;
    logic        flush;
    logic        w_accept;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        ld_busy;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_adel;
    logic        ld_timeout;

    int checkCount = 0;
    int errorCount = 0;

    m_ld_unit #(.BUS_TIMEOUT(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .ld_start_i   (ld_start),
        .ld_sel_i     (ld_sel),
        .ld_addr_i    (ld_addr),
        .flush_i      (flush),
        .w_accept_i   (w_accept),
        .dm_req_o     (dm_req),
        .dm_addr_o    (dm_addr),
        .dm_ready_i   (dm_ready),
        .dm_rdata_i   (dm_rdata),
        .ld_busy_o    (ld_busy),
        .ld_valid_o   (ld_valid),
        .ld_data_o    (ld_data),
        .ld_adel_o    (ld_adel),
        .ld_timeout_o (ld_timeout)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Safety net in case the run ever stops advancing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive every DUT input at once.
    task automatic applyStimulus(input logic start, input logic [2:0] sel,
                                 input logic [31:0] addr, input logic fl,
                                 input logic acc, input logic rdy,
                                 input logic [31:0] rdata);
        ld_start = start;
        ld_sel   = sel;
        ld_addr  = addr;
        flush    = fl;
        w_accept = acc;
        dm_ready = rdy;
        dm_rdata = rdata;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    endtask

    // Issue one load, answer after 'waits' wait cycles, and finish in HOLD.
    task automatic doLoad(input string tag, input logic [2:0] sel,
                          input logic [31:0] addr, input int waits,
                          input logic [31:0] rdata, input logic [31:0] expData);
        int busyCnt;
        applyStimulus(1'b1, sel, addr, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
        #1 checkOutput({tag, "_busy_start"}, 32'(ld_busy), 32'd1);
        nextCycle();
        idleInputs();
        busyCnt = 0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                dm_ready = 1'b1;
                dm_rdata = rdata;
            end
            #1;
            checkOutput({tag, "_req"}, 32'(dm_req), 32'd1);
            checkOutput({tag, "_addr"}, dm_addr, {addr[31:2], 2'b00});
            checkOutput({tag, "_valid_wait"}, 32'(ld_valid), 32'd0);
            if (ld_busy) busyCnt++;
            nextCycle();
        end
        idleInputs();
        #1;
        checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(waits + 1));
        checkOutput({tag, "_valid"}, 32'(ld_valid), 32'd1);
        checkOutput({tag, "_data"}, ld_data, expData);
        checkOutput({tag, "_req_done"}, 32'(dm_req), 32'd0);
        checkOutput({tag, "_busy_hold"}, 32'(ld_busy), 32'd0);
    endtask

    // W stage takes the held result.
    task automatic acceptLoad(input string tag);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        nextCycle();
        idleInputs();
        #1 checkOutput({tag, "_valid_after_accept"}, 32'(ld_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        repeat (3) nextCycle();
        #1;
        checkOutput("rst_req", 32'(dm_req), 32'd0);
        checkOutput("rst_addr", dm_addr, 32'h0);
        checkOutput("rst_valid", 32'(ld_valid), 32'd0);
        checkOutput("rst_data", ld_data, 32'h0);
        checkOutput("rst_adel", 32'(ld_adel), 32'd0);
        checkOutput("rst_timeout", 32'(ld_timeout), 32'd0);
        checkOutput("rst_busy", 32'(ld_busy), 32'd0);
        nextCycle();
        reset = 1'b0;

        // Byte loads from the top lane: 0x80 sign- and zero-extended.
        doLoad("lb", SEL_LB, 32'h0000_1003, 0, 32'h80FF_1234, 32'hFFFF_FF80);
        acceptLoad("lb");
        doLoad("lbu", SEL_LBU, 32'h0000_1003, 0, 32'h80FF_1234, 32'h0000_0080);
        acceptLoad("lbu");
        doLoad("lb1", SEL_LB, 32'h0000_1001, 1, 32'h80FF_1234, 32'h0000_0012);
        acceptLoad("lb1");

        // Half loads from both lanes.
        doLoad("lh_hi", SEL_LH, 32'h0000_1002, 0, 32'h8001_7FFF, 32'hFFFF_8001);
        acceptLoad("lh_hi");
        doLoad("lhu_hi", SEL_LHU, 32'h0000_1002, 0, 32'h8001_7FFF, 32'h0000_8001);
        acceptLoad("lhu_hi");
        doLoad("lh_lo", SEL_LH, 32'h0000_1000, 0, 32'h8001_7FFF, 32'h0000_7FFF);
        acceptLoad("lh_lo");

        // Misaligned word: one-cycle ADEL, no bus traffic, no stall.
        nextCycle();
        applyStimulus(1'b1, SEL_LW, 32'h0000_1001, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 checkOutput("adel_busy", 32'(ld_busy), 32'd0);
        nextCycle();
        idleInputs();
        #1;
        checkOutput("adel_pulse", 32'(ld_adel), 32'd1);
        checkOutput("adel_req", 32'(dm_req), 32'd0);
        nextCycle();
        #1;
        checkOutput("adel_clear", 32'(ld_adel), 32'd0);
        checkOutput("adel_req2", 32'(dm_req), 32'd0);

        // Misaligned half also traps; illegal selector is ignored.
        applyStimulus(1'b1, SEL_LHU, 32'h0000_1003, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        idleInputs();
        #1 checkOutput("adel_lhu", 32'(ld_adel), 32'd1);
        applyStimulus(1'b1, 3'd6, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 checkOutput("illegal_busy", 32'(ld_busy), 32'd0);
        nextCycle();
        idleInputs();
        #1;
        checkOutput("illegal_req", 32'(dm_req), 32'd0);
        checkOutput("illegal_adel", 32'(ld_adel), 32'd0);

        // Three wait cycles, result held, then back-to-back load on accept.
        doLoad("lw_wait", SEL_LW, 32'h0000_2000, 3, 32'h1234_5678, 32'h1234_5678);
        repeat (2) begin
            nextCycle();
            #1;
            checkOutput("hold_valid", 32'(ld_valid), 32'd1);
            checkOutput("hold_data", ld_data, 32'h1234_5678);
        end
        applyStimulus(1'b1, SEL_LW, 32'h0000_3004, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 checkOutput("b2b_busy", 32'(ld_busy), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        #1;
        checkOutput("b2b_valid_drop", 32'(ld_valid), 32'd0);
        checkOutput("b2b_req", 32'(dm_req), 32'd1);
        checkOutput("b2b_addr", dm_addr, 32'h0000_3004);
        nextCycle();
        idleInputs();
        #1;
        checkOutput("b2b_valid", 32'(ld_valid), 32'd1);
        checkOutput("b2b_data", ld_data, 32'hCAFE_F00D);

        // Flush while holding drops the result next cycle.
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        idleInputs();
        #1 checkOutput("hold_flush_valid", 32'(ld_valid), 32'd0);

        // Flush in REQ without ready: request kept until the bus answers.
        nextCycle();
        applyStimulus(1'b1, SEL_LW, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1 checkOutput("drain_req0", 32'(dm_req), 32'd1);
        nextCycle();
        idleInputs();
        #1;
        checkOutput("drain_req1", 32'(dm_req), 32'd1);
        checkOutput("drain_busy", 32'(ld_busy), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
        #1 checkOutput("drain_req2", 32'(dm_req), 32'd1);
        nextCycle();
        idleInputs();
        #1;
        checkOutput("drain_done_req", 32'(dm_req), 32'd0);
        checkOutput("drain_valid", 32'(ld_valid), 32'd0);
        checkOutput("drain_busy_end", 32'(ld_busy), 32'd0);

        // Flush together with ready in REQ discards the data.
        applyStimulus(1'b1, SEL_LW, 32'h0000_7000, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1111_2222);
        nextCycle();
        idleInputs();
        #1;
        checkOutput("flush_rdy_valid", 32'(ld_valid), 32'd0);
        checkOutput("flush_rdy_req", 32'(dm_req), 32'd0);

        // Flush beats a start in IDLE.
        applyStimulus(1'b1, SEL_LW, 32'h0000_8000, 1'b1, 1'b0, 1'b0, 32'h0);
        #1 checkOutput("flush_start_busy", 32'(ld_busy), 32'd0);
        nextCycle();
        idleInputs();
        #1 checkOutput("flush_start_req", 32'(dm_req), 32'd0);

        // No bus answer: timeout after four REQ cycles.
        applyStimulus(1'b1, SEL_LW, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        idleInputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("to_req", 32'(dm_req), 32'd1);
            checkOutput("to_early", 32'(ld_timeout), 32'd0);
            nextCycle();
        end
        #1;
        checkOutput("to_pulse", 32'(ld_timeout), 32'd1);
        checkOutput("to_req_drop", 32'(dm_req), 32'd0);
        checkOutput("to_busy", 32'(ld_busy), 32'd0);
        checkOutput("to_valid", 32'(ld_valid), 32'd0);
        nextCycle();
        #1 checkOutput("to_clear", 32'(ld_timeout), 32'd0);

        // Reset in the middle of a read drops the request silently.
        applyStimulus(1'b1, SEL_LW, 32'h0000_6000, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        idleInputs();
        #1 checkOutput("mid_rst_req_before", 32'(dm_req), 32'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_req", 32'(dm_req), 32'd0);
        checkOutput("mid_rst_valid", 32'(ld_valid), 32'd0);
        repeat (5) begin
            nextCycle();
            #1;
            checkOutput("mid_rst_timeout", 32'(ld_timeout), 32'd0);
            checkOutput("mid_rst_req_idle", 32'(dm_req), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
